// File: rtl/reg_fifo.sv
// Register-based FIFO with first-word-fall-through output and a sticky overflow flag.
// Defining REG_FIFO_COUNT_EN adds the count occupancy output.
module reg_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  d,
    input  logic          push,
    input  logic          pop,
    output logic [N-1:0]  z,
    output logic          empty,
    output logic          full,
    output logic          ovf
`ifdef REG_FIFO_COUNT_EN
    ,
    output logic [AW:0]   count
`endif
);

    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [N-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   occ_r;
    logic          ovf_r;

    logic          empty_s;
    logic          full_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic          drop_s;
    logic [AW:0]   occ_nxt_s;

    // Occupancy flags and accept decisions; a pop frees a slot for a same-cycle push.
    always_comb begin
        empty_s   = (occ_r == (AW+1)'(0));
        full_s    = (occ_r == OCC_FULL);
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
        drop_s    = push & full_s & ~do_pop_s;
    end

    // Next occupancy from the accepted operations.
    always_comb begin
        occ_nxt_s = occ_r;
        case ({do_push_s, do_pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_ONE;
            2'b01:   occ_nxt_s = occ_r - OCC_ONE;
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Pointer, occupancy and overflow state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            occ_r <= occ_nxt_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Storage is never cleared; stale entries stay hidden because occupancy gates z.
    always_ff @(posedge clk) begin
        if (do_push_s && !reset) begin
            mem_r[wr_ptr_r] <= d;
        end
    end

    // Head-of-queue output, forced to zero while empty.
    always_comb begin
        if (empty_s) begin
            z = '0;
        end else begin
            z = mem_r[rd_ptr_r];
        end
    end

    assign empty = empty_s;
    assign full  = full_s;
    assign ovf   = ovf_r;
`ifdef REG_FIFO_COUNT_EN
    assign count = occ_r;
`endif

endmodule

// File: tb/tb_reg_fifo.sv
// Self-checking bench for reg_fifo: directed vector table, reset corner cases and a
// scoreboard-checked random phase.
module tb_reg_fifo;

    logic        clk;
    logic        reset;
    logic [31:0] d;
    logic        push;
    logic        pop;
    logic [31:0] z;
    logic        empty;
    logic        full;
    logic        ovf;
`ifdef REG_FIFO_COUNT_EN
    logic [2:0]  count;
`endif

    reg_fifo #(.N(32), .DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .push  (push),
        .pop   (pop),
        .z     (z),
        .empty (empty),
        .full  (full),
        .ovf   (ovf)
`ifdef REG_FIFO_COUNT_EN
        ,
        .count (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pu;
        logic        po;
        logic [31:0] din;
        logic [31:0] ez;
        logic        ee;
        logic        ef;
        logic        eo;
        logic [2:0]  ec;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    logic        ovf_m;
    int          n_vec;
    int          n_err;

    function automatic void add(string t, logic pu, logic po, logic [31:0] din,
                                logic [31:0] ez, logic ee, logic ef, logic eo, logic [2:0] ec);
        vec_t v;
        v.tag = t; v.pu = pu; v.po = po; v.din = din;
        v.ez = ez; v.ee = ee; v.ef = ef; v.eo = eo; v.ec = ec;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(string t, logic [31:0] ez, logic ee, logic ef, logic eo, logic [2:0] ec);
        check({t, ".z"}, z, ez);
        check({t, ".empty"}, {31'd0, empty}, {31'd0, ee});
        check({t, ".full"}, {31'd0, full}, {31'd0, ef});
        check({t, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`ifdef REG_FIFO_COUNT_EN
        check({t, ".count"}, {29'd0, count}, {29'd0, ec});
`else
        if (ec > 3'd4) $display("bad count in table for %s", t);
`endif
    endtask

    // Drive one cycle of inputs just after an edge, then sample just after the next edge.
    task automatic step(logic pu, logic po, logic [31:0] din);
        push = pu; pop = po; d = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; ovf_m = 1'b0;
        reset = 1'b1; push = 1'b0; pop = 1'b0; d = 32'd0;

        // basic push/pop then drain
        add("p10",   1'b1, 1'b0, 32'd10,  32'd10,  1'b0, 1'b0, 1'b0, 3'd1);
        add("p20",   1'b1, 1'b0, 32'd20,  32'd10,  1'b0, 1'b0, 1'b0, 3'd2);
        add("p30",   1'b1, 1'b0, 32'd30,  32'd10,  1'b0, 1'b0, 1'b0, 3'd3);
        add("pop1",  1'b0, 1'b1, 32'd0,   32'd20,  1'b0, 1'b0, 1'b0, 3'd2);
        add("pop2",  1'b0, 1'b1, 32'd0,   32'd30,  1'b0, 1'b0, 1'b0, 3'd1);
        add("pop3",  1'b0, 1'b1, 32'd0,   32'd0,   1'b1, 1'b0, 1'b0, 3'd0);
        // push+pop while full
        add("f1",    1'b1, 1'b0, 32'd1,   32'd1,   1'b0, 1'b0, 1'b0, 3'd1);
        add("f2",    1'b1, 1'b0, 32'd2,   32'd1,   1'b0, 1'b0, 1'b0, 3'd2);
        add("f3",    1'b1, 1'b0, 32'd3,   32'd1,   1'b0, 1'b0, 1'b0, 3'd3);
        add("f4",    1'b1, 1'b0, 32'd4,   32'd1,   1'b0, 1'b1, 1'b0, 3'd4);
        add("fpp9",  1'b1, 1'b1, 32'd9,   32'd2,   1'b0, 1'b1, 1'b0, 3'd4);
        add("fpa",   1'b0, 1'b1, 32'd0,   32'd3,   1'b0, 1'b0, 1'b0, 3'd3);
        add("fpb",   1'b0, 1'b1, 32'd0,   32'd4,   1'b0, 1'b0, 1'b0, 3'd2);
        add("fpc",   1'b0, 1'b1, 32'd0,   32'd9,   1'b0, 1'b0, 1'b0, 3'd1);
        add("fpd",   1'b0, 1'b1, 32'd0,   32'd0,   1'b1, 1'b0, 1'b0, 3'd0);
        // push+pop while empty, pop while empty
        add("epp7",  1'b1, 1'b1, 32'd7,   32'd7,   1'b0, 1'b0, 1'b0, 3'd1);
        add("epop",  1'b0, 1'b1, 32'd0,   32'd0,   1'b1, 1'b0, 1'b0, 3'd0);
        add("eidle", 1'b0, 1'b1, 32'd55,  32'd0,   1'b1, 1'b0, 1'b0, 3'd0);
        // streaming through pointer wrap
        add("w100",  1'b1, 1'b0, 32'd100, 32'd100, 1'b0, 1'b0, 1'b0, 3'd1);
        add("w101",  1'b1, 1'b1, 32'd101, 32'd101, 1'b0, 1'b0, 1'b0, 3'd1);
        add("w102",  1'b1, 1'b1, 32'd102, 32'd102, 1'b0, 1'b0, 1'b0, 3'd1);
        add("w103",  1'b1, 1'b1, 32'd103, 32'd103, 1'b0, 1'b0, 1'b0, 3'd1);
        add("w104",  1'b1, 1'b1, 32'd104, 32'd104, 1'b0, 1'b0, 1'b0, 3'd1);
        add("w105",  1'b1, 1'b1, 32'd105, 32'd105, 1'b0, 1'b0, 1'b0, 3'd1);
        add("wend",  1'b0, 1'b1, 32'd0,   32'd0,   1'b1, 1'b0, 1'b0, 3'd0);
        // overflow and sticky ovf
        add("o1",    1'b1, 1'b0, 32'd1,   32'd1,   1'b0, 1'b0, 1'b0, 3'd1);
        add("o2",    1'b1, 1'b0, 32'd2,   32'd1,   1'b0, 1'b0, 1'b0, 3'd2);
        add("o3",    1'b1, 1'b0, 32'd3,   32'd1,   1'b0, 1'b0, 1'b0, 3'd3);
        add("o4",    1'b1, 1'b0, 32'd4,   32'd1,   1'b0, 1'b1, 1'b0, 3'd4);
        add("o5",    1'b1, 1'b0, 32'd5,   32'd1,   1'b0, 1'b1, 1'b1, 3'd4);
        add("oa",    1'b0, 1'b1, 32'd0,   32'd2,   1'b0, 1'b0, 1'b1, 3'd3);
        add("ob",    1'b0, 1'b1, 32'd0,   32'd3,   1'b0, 1'b0, 1'b1, 3'd2);
        add("oc",    1'b0, 1'b1, 32'd0,   32'd4,   1'b0, 1'b0, 1'b1, 3'd1);
        add("od",    1'b0, 1'b1, 32'd0,   32'd0,   1'b1, 1'b0, 1'b1, 3'd0);

        #1;
        check_outs("rst", 32'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        // push held during a reset edge must be ignored
        push = 1'b1; d = 32'hdead;
        @(posedge clk);
        #1;
        check_outs("rsthold", 32'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        push = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].pu, vecs[i].po, vecs[i].din);
            check_outs(vecs[i].tag, vecs[i].ez, vecs[i].ee, vecs[i].ef, vecs[i].eo, vecs[i].ec);
        end

        // asynchronous reset between edges with three entries held and ovf set
        step(1'b1, 1'b0, 32'd11);
        step(1'b1, 1'b0, 32'd12);
        step(1'b1, 1'b0, 32'd13);
        push = 1'b0; pop = 1'b0;
        check_outs("pre_ar", 32'd11, 1'b0, 1'b0, 1'b1, 3'd3);
        #3 reset = 1'b1;
        #1;
        check_outs("async_rst", 32'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        push = 1'b1; pop = 1'b1; d = 32'd77;
        @(posedge clk);
        #1;
        check_outs("rst_ign", 32'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        push = 1'b0; pop = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_rst", 32'd0, 1'b1, 1'b0, 1'b0, 3'd0);

        // scoreboard-checked random traffic
        for (int c = 0; c < 400; c++) begin
            logic        pu, po, acc_pop, acc_push;
            logic [31:0] dv;
            pu = ($urandom_range(0, 9) < 6);
            po = ($urandom_range(0, 9) < 5);
            dv = $urandom;
            acc_pop  = po && (sb_q.size() > 0);
            acc_push = pu && ((sb_q.size() < 4) || acc_pop);
            if (pu && !acc_push) ovf_m = 1'b1;
            step(pu, po, dv);
            if (acc_pop) void'(sb_q.pop_front());
            if (acc_push) sb_q.push_back(dv);
            check_outs("rnd", (sb_q.size() > 0) ? sb_q[0] : 32'd0, sb_q.size() == 0,
                       sb_q.size() == 4, ovf_m, 3'(sb_q.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
